// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared constants, FI tables and codeword decode for the adaptation speed control
package adpcm_pkg;
  typedef enum logic [1:0] {
    RATE_16K = 2'b00,
    RATE_24K = 2'b01,
    RATE_32K = 2'b10,
    RATE_40K = 2'b11
  } rate_e;
  localparam logic [1:0][2:0] FI_16K = {3'd7, 3'd0};
  localparam logic [3:0][2:0] FI_24K = {3'd7, 3'd2, 3'd1, 3'd0};
  localparam logic [7:0][2:0] FI_32K = {3'd7, 3'd3, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
  localparam logic [15:0][2:0] FI_40K = {3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd1,
                                         3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [12:0] Y_THR = 13'd1536;
  localparam logic [9:0] TR_LOAD = 10'd256;
  localparam logic [6:0] AL_SAT = 7'd64;
  localparam logic [9:0] AP_RST_DEF = 10'd0;
  localparam logic [11:0] DMS_RST_DEF = 12'd0;
  localparam logic [13:0] DML_RST_DEF = 14'd0;
  // one's-complement magnitude over the rate-dependent width, then table lookup
  function automatic logic [2:0] fi_of(input logic [1:0] rate, input logic [4:0] i);
    logic [3:0] im;
    im = rate == RATE_16K ? {3'b0, i[1] ? ~i[0] : i[0]}
       : rate == RATE_24K ? {2'b0, i[2] ? ~i[1:0] : i[1:0]}
       : rate == RATE_32K ? {1'b0, i[3] ? ~i[2:0] : i[2:0]}
       : (i[4] ? ~i[3:0] : i[3:0]);
    return rate == RATE_16K ? FI_16K[im[0]]
         : rate == RATE_24K ? FI_24K[im[1:0]]
         : rate == RATE_32K ? FI_32K[im[2:0]]
         : FI_40K[im];
  endfunction
endpackage

// File: rtl/asc_leak_filt.sv
// asc_leak_filt: leaky accumulator q += ((x<<INSHIFT) - q) >>> SHIFT, with load override and scan shift
module asc_leak_filt #(
  parameter int WIDTH = 12,
  parameter int SHIFT = 5,
  parameter int INSHIFT = 9,
  parameter logic [WIDTH-1:0] RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [2:0]       x,
  input  logic             se,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             so
);
  logic [WIDTH-1:0] tgt;
  logic signed [WIDTH:0] dif;
  assign tgt = WIDTH'(x) << INSHIFT;
  // one extra bit so the difference sign-extends before the arithmetic shift
  assign dif = $signed({1'b0, tgt}) - $signed({1'b0, q});
  assign nxt = q + WIDTH'(dif >>> SHIFT);
  assign so = q[WIDTH-1];
  always_ff @(posedge clk)
    if (!reset) q <= RST;
    else if (se) q <= {q[WIDTH-2:0], si};
    else if (en) q <= ld ? ld_val : nxt;
endmodule

// File: rtl/adap_speed_ctl.sv
// adap_speed_ctl: G.726 adaptation speed control, tracks DMS/DML/AP and derives AL
module adap_speed_ctl
  import adpcm_pkg::*;
#(
  parameter logic [9:0]  AP_RST  = AP_RST_DEF,
  parameter logic [11:0] DMS_RST = DMS_RST_DEF,
  parameter logic [13:0] DML_RST = DML_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dly_strb,
  input  logic [4:0]  I,
  input  logic [1:0]  RATE,
  input  logic [12:0] Y,
  input  logic        TDP,
  input  logic        TR,
  output logic [6:0]  AL,
  input  logic        scan_in0,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0
);
  logic [2:0] fi;
  logic [11:0] dms, dmsp;
  logic [13:0] dml, dmlp;
  logic [9:0] ap, app;
  logic signed [14:0] dif;
  logic [14:0] difm;
  logic ax, so_dms, so_dml, unused_tm;
  assign unused_tm = test_mode;
  assign fi = fi_of(RATE, I);
  asc_leak_filt #(.WIDTH(12), .SHIFT(5), .INSHIFT(9), .RST(DMS_RST)) u_dms (
    .clk(clk), .reset(reset), .en(dly_strb), .ld(1'b0), .ld_val('0), .x(fi),
    .se(scan_enable), .si(scan_in0), .q(dms), .nxt(dmsp), .so(so_dms)
  );
  asc_leak_filt #(.WIDTH(14), .SHIFT(7), .INSHIFT(11), .RST(DML_RST)) u_dml (
    .clk(clk), .reset(reset), .en(dly_strb), .ld(1'b0), .ld_val('0), .x(fi),
    .se(scan_enable), .si(so_dms), .q(dml), .nxt(dmlp), .so(so_dml)
  );
  assign dif = $signed({1'b0, dmsp, 2'b00}) - $signed({1'b0, dmlp});
  assign difm = dif[14] ? 15'(-dif) : 15'(dif);
  assign ax = (difm >= 15'(dmlp >> 3)) || (Y < Y_THR) || TDP;
  asc_leak_filt #(.WIDTH(10), .SHIFT(4), .INSHIFT(9), .RST(AP_RST)) u_ap (
    .clk(clk), .reset(reset), .en(dly_strb), .ld(TR), .ld_val(TR_LOAD), .x({2'b00, ax}),
    .se(scan_enable), .si(so_dml), .q(ap), .nxt(app), .so(scan_out0)
  );
  assign AL = ap >= TR_LOAD ? AL_SAT : 7'(ap >> 2);
endmodule

// File: tb/tb_adap_speed_ctl.sv
// tb_adap_speed_ctl: table vectors plus scoreboarded sequences against an integer reference model
module tb_adap_speed_ctl;
  logic clk = 0, reset = 0, dly_strb = 0, TDP = 0, TR = 0;
  logic scan_in0 = 0, scan_enable = 0, test_mode = 0, scan_out0;
  logic [4:0] I = 0;
  logic [1:0] RATE = 0;
  logic [12:0] Y = 0;
  logic [6:0] AL;

  adap_speed_ctl dut (
    .clk(clk), .reset(reset), .dly_strb(dly_strb), .I(I), .RATE(RATE), .Y(Y),
    .TDP(TDP), .TR(TR), .AL(AL), .scan_in0(scan_in0), .scan_enable(scan_enable),
    .test_mode(test_mode), .scan_out0(scan_out0)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int m_dms = 0, m_dml = 0, m_ap = 0;
  typedef struct {int al; int dms; int dml; int ap;} exp_t;
  exp_t sb[$];
  typedef struct {
    logic [1:0] rate; logic [4:0] i; logic [12:0] y; bit tdp; bit tr; int dms; int al;
  } vec_t;
  vec_t vt[10];
  int fi16[2] = '{0, 7};
  int fi24[4] = '{0, 1, 2, 7};
  int fi32[8] = '{0, 0, 0, 1, 1, 1, 3, 7};
  int fi40[16] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 6};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_fi(input int rate, input int i);
    int n, mask, im;
    n = rate + 2;
    mask = (1 << (n - 1)) - 1;
    im = ((i >> (n - 1)) & 1) != 0 ? (~i) & mask : i & mask;
    case (rate)
      0: return fi16[im];
      1: return fi24[im];
      2: return fi32[im];
      default: return fi40[im];
    endcase
  endfunction

  function automatic int model_al(input int ap);
    return ap >= 256 ? 64 : ap / 4;
  endfunction

  task automatic model_step(input int r, input int i, input int y, input bit tdp, input bit tr);
    int fi, dmsp, dmlp, dif, difm, app;
    bit ax;
    exp_t e;
    fi = model_fi(r, i);
    dmsp = (m_dms + ((fi * 512 - m_dms) >>> 5)) & 4095;
    dmlp = (m_dml + ((fi * 2048 - m_dml) >>> 7)) & 16383;
    dif = dmsp * 4 - dmlp;
    difm = dif < 0 ? -dif : dif;
    ax = (difm >= dmlp / 8) || (y < 1536) || tdp;
    app = (m_ap + (((ax ? 512 : 0) - m_ap) >>> 4)) & 1023;
    m_ap = tr ? 256 : app;
    m_dms = dmsp;
    m_dml = dmlp;
    e = '{model_al(m_ap), m_dms, m_dml, m_ap};
    sb.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_al"}, int'(AL), e.al);
    check({tag, "_dms"}, int'(dut.u_dms.q), e.dms);
    check({tag, "_dml"}, int'(dut.u_dml.q), e.dml);
    check({tag, "_ap"}, int'(dut.u_ap.q), e.ap);
  endtask

  task automatic step(input logic [1:0] r, input logic [4:0] i, input logic [12:0] y,
                      input bit tdp, input bit tr, input string tag);
    @(negedge clk);
    RATE = r; I = i; Y = y; TDP = tdp; TR = tr; dly_strb = 1;
    model_step(int'(r), int'(i), int'(y), tdp, tr);
    @(posedge clk);
    #1 dly_strb = 0;
    compare_pop(tag);
  endtask

  // reset held 3 clocks with a strobe pending; nothing may leak through
  task automatic do_reset();
    @(negedge clk);
    reset = 0; dly_strb = 1; RATE = 2'b10; I = 5'b00111; Y = 13'd2000; TR = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_al", int'(AL), 0);
    check("rst_dms", int'(dut.u_dms.q), 0);
    check("rst_dml", int'(dut.u_dml.q), 0);
    check("rst_ap", int'(dut.u_ap.q), 0);
    @(negedge clk);
    reset = 1; dly_strb = 0; TR = 0;
    m_dms = 0; m_dml = 0; m_ap = 0;
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b10, 5'b00111, 13'd2000, 1'b0, 1'b0, 112, 8};
    vt[1] = '{2'b10, 5'b01111, 13'd1000, 1'b0, 1'b0, 0, 8};
    vt[2] = '{2'b10, 5'b01111, 13'd1535, 1'b0, 1'b0, 0, 8};
    vt[3] = '{2'b10, 5'b01111, 13'd1536, 1'b0, 1'b0, 0, 8};
    vt[4] = '{2'b00, 5'b00001, 13'd2000, 1'b0, 1'b0, 112, 8};
    vt[5] = '{2'b00, 5'b00010, 13'd2000, 1'b0, 1'b0, 112, 8};
    vt[6] = '{2'b01, 5'b00010, 13'd2000, 1'b0, 1'b0, 32, 8};
    vt[7] = '{2'b11, 5'b00000, 13'd2000, 1'b0, 1'b1, 0, 64};
    vt[8] = '{2'b11, 5'b01111, 13'd2000, 1'b0, 1'b0, 96, 8};
    vt[9] = '{2'b11, 5'b10000, 13'd2000, 1'b1, 1'b0, 96, 8};

    do_reset();

    // scan chain: 36 flops, a 1 reaches scan_out0 on the 36th shift
    scan_enable = 1; scan_in0 = 1;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (k == 35) check("scan_out_35", int'(scan_out0), 0);
      if (k == 36) check("scan_out_36", int'(scan_out0), 1);
    end
    scan_enable = 0; scan_in0 = 0;

    for (int v = 0; v < 10; v++) begin
      do_reset();
      step(vt[v].rate, vt[v].i, vt[v].y, vt[v].tdp, vt[v].tr, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_dms", v), int'(dut.u_dms.q), vt[v].dms);
      check($sformatf("vec%0d_tbl_al", v), int'(AL), vt[v].al);
    end

    // TR forces 256, then AX=1 strobes keep AL saturated
    do_reset();
    step(2'b10, 5'b00011, 13'd3000, 1'b0, 1'b1, "tr_load");
    check("tr_load_al", int'(AL), 64);
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 5'b00011, 13'd1000, 1'b0, 1'b0, "tr_hold");
      check("tr_hold_al", int'(AL), 64);
    end

    // strobe low: toggling inputs must not disturb state
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      I = 5'($urandom); Y = 13'($urandom); TR = ~TR; TDP = 1'($urandom);
      @(posedge clk);
      #1 check("idle_al", int'(AL), model_al(m_ap));
    end
    check("idle_dms", int'(dut.u_dms.q), m_dms);
    check("idle_dml", int'(dut.u_dml.q), m_dml);
    check("idle_ap", int'(dut.u_ap.q), m_ap);
    TR = 0; TDP = 0;

    // reset coincident with a strobe discards the sample
    @(negedge clk);
    reset = 0; dly_strb = 1; RATE = 2'b11; I = 5'b01110; Y = 13'd4000; TR = 1;
    @(posedge clk);
    #1 dly_strb = 0; TR = 0;
    check("rst_strb_al", int'(AL), 0);
    check("rst_strb_dms", int'(dut.u_dms.q), 0);
    check("rst_strb_ap", int'(dut.u_ap.q), 0);
    @(negedge clk);
    reset = 1;
    m_dms = 0; m_dml = 0; m_ap = 0;

    for (int c = 0; c < 32; c++) begin
      int im;
      do_reset();
      step(2'b11, c[4:0], 13'd2000, 1'b0, 1'b0, "sweep");
      im = c[4] ? (~c) & 15 : c & 15;
      check($sformatf("sweep%0d_dms", c), int'(dut.u_dms.q), fi40[im] * 16);
    end

    // steady FI drives DIF toward zero, so AX drops and AP leaks away
    do_reset();
    for (int k = 0; k < 600; k++) step(2'b10, 5'b00111, 13'd2000, 1'b0, 1'b0, "decay");
    check("decay_al_final", int'(AL), 0);

    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(2'($urandom), 5'($urandom), 13'($urandom_range(1000, 4000)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, "rand");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
